// File: rtl/alt_vipitc131_common_video_packet_encode.sv
// Avalon-ST Video packet encoder: frames pixel beats into video data packets
// and emits control packets (width/height/interlaced) on request.
module alt_vipitc131_common_video_packet_encode #(
    parameter int unsigned BITS_PER_SYMBOL  = 8,
    parameter int unsigned SYMBOLS_PER_BEAT = 3
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] din_data,
    input  logic                                        din_valid,
    output logic                                        din_ready,
    input  logic                                        din_end_of_video,
    input  logic                                        vip_ctrl_send,
    output logic                                        vip_ctrl_busy,
    input  logic [15:0]                                 width,
    input  logic [15:0]                                 height,
    input  logic [3:0]                                  interlaced,
    output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] dout_data,
    output logic                                        dout_valid,
    input  logic                                        dout_ready,
    output logic                                        dout_startofpacket,
    output logic                                        dout_endofpacket
);

    localparam int unsigned BPS        = BITS_PER_SYMBOL;
    localparam int unsigned SPB        = SYMBOLS_PER_BEAT;
    localparam int unsigned DW         = BPS * SPB;
    localparam int unsigned CTRL_BEATS = (9 + SPB - 1) / SPB;
    localparam int unsigned IDX_W      = (CTRL_BEATS > 1) ? $clog2(CTRL_BEATS) : 1;
    localparam int unsigned NUM_SLOTS  = 2 ** IDX_W;
    localparam int unsigned PAD_W      = 4 * CTRL_BEATS * SPB;

    typedef enum logic [2:0] {
        IDLE,
        CTRL_HDR,
        CTRL_BODY,
        DATA_HDR,
        DATA
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             ctrl_pend, ctrl_pend_nxt;
    logic [15:0]      width_q, height_q;
    logic [3:0]       interlaced_q;
    logic             capture;
    logic             body_last_acc;

    assign capture       = vip_ctrl_send && !ctrl_pend;
    assign vip_ctrl_busy = ctrl_pend;

    // Body nibbles in transmit order; symbol 0 of beat 0 sits in bits [3:0].
    logic [35:0]      body;
    logic [PAD_W-1:0] body_pad;
    assign body = {interlaced_q,
                   height_q[3:0], height_q[7:4], height_q[11:8], height_q[15:12],
                   width_q[3:0],  width_q[7:4],  width_q[11:8],  width_q[15:12]};
    assign body_pad = PAD_W'(body);

    logic [DW-1:0] body_beats [NUM_SLOTS];

    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_beat
        logic [DW-1:0] beat;
        for (genvar s = 0; s < SPB; s++) begin : g_sym
            if (k < CTRL_BEATS) begin : g_used
                assign beat[s*BPS +: BPS] = BPS'(body_pad[(k*SPB+s)*4 +: 4]);
            end else begin : g_pad
                assign beat[s*BPS +: BPS] = '0;
            end
        end
        assign body_beats[k] = beat;
    end

    // State, beat index and latched control values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            ctrl_pend    <= 1'b0;
            width_q      <= '0;
            height_q     <= '0;
            interlaced_q <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            ctrl_pend <= ctrl_pend_nxt;
            if (capture) begin
                width_q      <= width;
                height_q     <= height;
                interlaced_q <= interlaced;
            end
        end
    end

    always_comb begin
        ctrl_pend_nxt = ctrl_pend;
        if (body_last_acc) ctrl_pend_nxt = 1'b0;
        if (capture)       ctrl_pend_nxt = 1'b1;
    end

    // Next state and beat outputs; DATA is a zero-latency pass-through.
    always_comb begin
        state_nxt          = state;
        idx_nxt            = idx;
        body_last_acc      = 1'b0;
        dout_valid         = 1'b0;
        din_ready          = 1'b0;
        dout_data          = '0;
        dout_startofpacket = 1'b0;
        dout_endofpacket   = 1'b0;
        case (state)
            IDLE: begin
                // A request arriving this cycle is served before pending pixels.
                if (ctrl_pend)          state_nxt = CTRL_HDR;
                else if (vip_ctrl_send) state_nxt = IDLE;
                else if (din_valid)     state_nxt = DATA_HDR;
            end
            CTRL_HDR: begin
                dout_valid         = 1'b1;
                dout_startofpacket = 1'b1;
                dout_data          = DW'(4'hF);
                if (dout_ready) begin
                    state_nxt = CTRL_BODY;
                    idx_nxt   = '0;
                end
            end
            CTRL_BODY: begin
                dout_valid       = 1'b1;
                dout_data        = body_beats[idx];
                dout_endofpacket = (idx == IDX_W'(CTRL_BEATS - 1));
                if (dout_ready) begin
                    if (dout_endofpacket) begin
                        body_last_acc = 1'b1;
                        idx_nxt       = '0;
                        state_nxt     = IDLE;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            DATA_HDR: begin
                dout_valid         = 1'b1;
                dout_startofpacket = 1'b1;
                if (dout_ready) state_nxt = DATA;
            end
            DATA: begin
                dout_valid       = din_valid;
                dout_data        = din_data;
                din_ready        = dout_ready;
                dout_endofpacket = din_end_of_video && din_valid;
                if (din_valid && dout_ready && din_end_of_video) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
